// File: rtl/cnn_stream_driver.sv
// cnn_stream_driver: streams image/filter windows into a conv layer, reads back
// one result per window after RD_LAT cycles and keeps them for readout.
module cnn_stream_driver #(
  parameter int NUM_WIN = 5,
  parameter int RD_LAT  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_we,
  input  logic       cfg_sel,
  input  logic [2:0] cfg_addr,
  input  logic [3:0] cfg_data,
  input  logic       go,
  output logic       busy,
  output logic       done,
  output logic [3:0] Image,
  output logic [3:0] Filter,
  output logic       Start,
  output logic       ReadEn,
  input  logic [9:0] ConvResult,
  input  logic [2:0] res_addr,
  output logic [9:0] res_data
);
  localparam logic [2:0] IDLE = 3'd0, STREAM = 3'd1, GAP = 3'd2, READ = 3'd3, DRAIN = 3'd4, DONE = 3'd5;
  logic [3:0] r_img [7];
  logic [3:0] r_flt [3];
  logic [9:0] r_res [5];
  logic [2:0] r_state, w_nstate;
  logic [3:0] r_cnt, w_ncnt, w_len;
  logic [2:0] r_w, w_nw, w_idx, r_cap;
  logic [1:0] r_t, w_nt;
  logic w_end;
  logic [RD_LAT-1:0] r_pipe;
  logic [RD_LAT:0] w_pipe;
  logic r_busy, r_done, r_start, r_readen;
  logic [3:0] r_image, r_filter;
  // States after IDLE are encoded consecutively so a finished state steps to the next.
  always_comb begin
    w_len = r_state == STREAM ? 4'(3 * NUM_WIN) : r_state == READ ? 4'(NUM_WIN) : r_state == DRAIN ? 4'(RD_LAT) : 4'd1;
    w_end = r_cnt == w_len - 4'd1;
    w_nstate = r_state == IDLE ? (go ? STREAM : IDLE) : !w_end ? r_state : r_state == DONE ? IDLE : r_state + 3'd1;
    w_ncnt = (r_state == IDLE || w_end) ? 4'd0 : r_cnt + 4'd1;
    w_nw = r_state != STREAM ? 3'd0 : r_t == 2'd2 ? r_w + 3'd1 : r_w;
    w_nt = (r_state != STREAM || r_t == 2'd2) ? 2'd0 : r_t + 2'd1;
    w_idx = w_nw + {1'b0, w_nt};
    w_pipe = {r_pipe, r_readen};
  end
  // Outputs are registered from the next-state view so they line up with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_w <= '0;
      r_t <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_start <= 1'b0;
      r_readen <= 1'b0;
      r_image <= '0;
      r_filter <= '0;
      r_pipe <= '0;
      r_cap <= '0;
      for (int i = 0; i < 7; i++) r_img[i] <= '0;
      for (int i = 0; i < 3; i++) r_flt[i] <= '0;
      for (int i = 0; i < 5; i++) r_res[i] <= '0;
    end else begin
      r_state <= w_nstate;
      r_cnt <= w_ncnt;
      r_w <= w_nw;
      r_t <= w_nt;
      r_busy <= w_nstate != IDLE;
      r_done <= w_nstate == DONE;
      r_start <= w_nstate == STREAM;
      r_readen <= w_nstate == READ;
      r_image <= w_nstate == STREAM ? r_img[w_idx] : '0;
      r_filter <= w_nstate == STREAM ? r_flt[w_nt] : '0;
      if (cfg_we && r_state == IDLE) begin
        if (cfg_sel && cfg_addr < 3'd3) r_flt[cfg_addr[1:0]] <= cfg_data;
        if (!cfg_sel && cfg_addr < 3'd7) r_img[cfg_addr] <= cfg_data;
      end
      r_pipe <= w_pipe[RD_LAT-1:0];
      if (r_state == IDLE) r_cap <= '0;
      else if (w_pipe[RD_LAT] && r_cap < 3'(NUM_WIN)) begin
        r_res[r_cap] <= ConvResult;
        r_cap <= r_cap + 3'd1;
      end
    end
  end
  assign busy = r_busy;
  assign done = r_done;
  assign Start = r_start;
  assign ReadEn = r_readen;
  assign Image = r_image;
  assign Filter = r_filter;
  assign res_data = res_addr < 3'(NUM_WIN) ? r_res[res_addr] : '0;
endmodule

// File: tb/tb_cnn_stream_driver.sv
// tb_cnn_stream_driver: two instances (5 windows/latency 1 and 1 window/latency 3)
// driven by a conv-layer responder and checked against an array-level model.
module tb_cnn_stream_driver;
  logic clk = 1'b0;
  logic rst, cfg_we, cfg_sel, go;
  logic [2:0] cfg_addr, res_addr;
  logic [3:0] cfg_data;
  logic busy [2], done [2], start [2], readen [2];
  logic [3:0] image [2], filter [2];
  logic [9:0] conv [2], res_data [2];
  int nw [2] = '{5, 1};
  int lat [2] = '{1, 3};
  int n_cmp = 0, n_bad = 0, cyc = 0, go_cyc = 0;
  int img_m [2][7], flt_m [2][3], s_img [2][7], s_flt [2][3];
  int acc [2], taps [2], sums [2][5], pend [2][4];
  int st_first [2], st_last [2], re_first [2], re_n [2], ndone [2], done_cyc [2];

  cnn_stream_driver #(.NUM_WIN(5), .RD_LAT(1)) u0 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .go(go), .busy(busy[0]), .done(done[0]), .Image(image[0]), .Filter(filter[0]), .Start(start[0]),
    .ReadEn(readen[0]), .ConvResult(conv[0]), .res_addr(res_addr), .res_data(res_data[0]));
  cnn_stream_driver #(.NUM_WIN(1), .RD_LAT(3)) u1 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .go(go), .busy(busy[1]), .done(done[1]), .Image(image[1]), .Filter(filter[1]), .Start(start[1]),
    .ReadEn(readen[1]), .ConvResult(conv[1]), .res_addr(res_addr), .res_data(res_data[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Conv layer stand-in: multiplies what is streamed, returns window sums RD_LAT after ReadEn.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      automatic int s = cyc % 4;
      automatic int k = taps[i];
      conv[i] = pend[i][s] >= 0 ? 10'(pend[i][s]) : 10'($urandom_range(1023));
      pend[i][s] = -1;
      if (start[i]) begin
        if (k < 3 * nw[i]) begin
          check($sformatf("u%0d.image%0d", i, k), 32'(image[i]), 32'(s_img[i][k / 3 + k % 3]));
          check($sformatf("u%0d.filter%0d", i, k), 32'(filter[i]), 32'(s_flt[i][k % 3]));
        end
        acc[i] += image[i] * filter[i];
        if (k % 3 == 2 && k / 3 < 5) begin
          sums[i][k / 3] = acc[i];
          acc[i] = 0;
        end
        if (st_first[i] < 0) st_first[i] = cyc;
        st_last[i] = cyc;
        taps[i]++;
      end
      if (readen[i]) begin
        if (re_first[i] < 0) re_first[i] = cyc;
        pend[i][(cyc + lat[i]) % 4] = re_n[i] < 5 ? sums[i][re_n[i]] : 0;
        re_n[i]++;
      end
      if (done[i]) begin
        ndone[i]++;
        done_cyc[i] = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(bit sel, int a, int d);
    cfg_we = 1'b1;
    cfg_sel = sel;
    cfg_addr = 3'(a);
    cfg_data = 4'(d);
    for (int i = 0; i < 2; i++)
      if (!busy[i]) begin
        if (sel && a < 3) flt_m[i][a] = d;
        if (!sel && a < 7) img_m[i][a] = d;
      end
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic load(int im [7], int fl [3]);
    for (int a = 0; a < 7; a++) cfg_write(1'b0, a, im[a]);
    for (int a = 0; a < 3; a++) cfg_write(1'b1, a, fl[a]);
  endtask

  task automatic arm();
    for (int i = 0; i < 2; i++) begin
      acc[i] = 0; taps[i] = 0; re_n[i] = 0; ndone[i] = 0;
      st_first[i] = -1; re_first[i] = -1; done_cyc[i] = -1;
      s_img[i] = img_m[i];
      s_flt[i] = flt_m[i];
      for (int w = 0; w < 5; w++) sums[i][w] = 0;
    end
    go = 1'b1;
    go_cyc = cyc;
    tick();
    go = 1'b0;
  endtask

  task automatic check_res(bit cleared);
    for (int a = 0; a < 8; a++) begin
      res_addr = 3'(a);
      tick();
      for (int i = 0; i < 2; i++) begin
        automatic int e = 0;
        if (!cleared && a < nw[i])
          for (int t = 0; t < 3; t++) e += s_img[i][a + t] * s_flt[i][t];
        check($sformatf("u%0d.res%0d", i, a), 32'(res_data[i]), 32'(e));
      end
    end
  endtask

  task automatic run(bit disturb);
    arm();
    for (int c = 0; c < 60 && !(ndone[0] > 0 && ndone[1] > 0); c++) begin
      tick();
      if (disturb && c < 6 && c % 2 == 0) begin
        go = 1'b1;
        cfg_we = 1'b1;
        cfg_sel = 1'($urandom_range(1));
        cfg_addr = 3'($urandom_range(7));
        cfg_data = 4'($urandom_range(15));
      end else begin
        go = 1'b0;
        cfg_we = 1'b0;
      end
    end
    go = 1'b0;
    cfg_we = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("u%0d.start_first", i), 32'(st_first[i] - go_cyc), 32'd1);
      check($sformatf("u%0d.start_last", i), 32'(st_last[i] - go_cyc), 32'(3 * nw[i]));
      check($sformatf("u%0d.start_cycles", i), 32'(taps[i]), 32'(3 * nw[i]));
      check($sformatf("u%0d.readen_first", i), 32'(re_first[i] - go_cyc), 32'(3 * nw[i] + 2));
      check($sformatf("u%0d.readen_cycles", i), 32'(re_n[i]), 32'(nw[i]));
      check($sformatf("u%0d.done_cycle", i), 32'(done_cyc[i] - go_cyc), 32'(4 * nw[i] + 2 + lat[i]));
      check($sformatf("u%0d.done_count", i), 32'(ndone[i]), 32'd1);
      check($sformatf("u%0d.busy_after", i), 32'(busy[i]), 32'd0);
    end
    check_res(1'b0);
  endtask

  task automatic check_idle_outputs(string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s.u%0d.busy", tag, i), 32'(busy[i]), 32'd0);
      check($sformatf("%s.u%0d.start", tag, i), 32'(start[i]), 32'd0);
      check($sformatf("%s.u%0d.readen", tag, i), 32'(readen[i]), 32'd0);
      check($sformatf("%s.u%0d.done", tag, i), 32'(done[i]), 32'd0);
      check($sformatf("%s.u%0d.image", tag, i), 32'(image[i]), 32'd0);
      check($sformatf("%s.u%0d.filter", tag, i), 32'(filter[i]), 32'd0);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 7; a++) img_m[i][a] = 0;
      for (int a = 0; a < 3; a++) flt_m[i][a] = 0;
    end
  endtask

  initial begin
    automatic int im [7];
    automatic int fl [3];
    for (int i = 0; i < 2; i++) for (int s = 0; s < 4; s++) pend[i][s] = -1;
    rst = 1'b1; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0; go = 1'b0; res_addr = '0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    check_idle_outputs("reset");
    for (int i = 0; i < 2; i++) s_img[i] = img_m[i];
    check_res(1'b1);
    im = '{1, 2, 3, 4, 5, 6, 7};
    fl = '{1, 2, 3};
    load(im, fl);
    run(1'b0);
    res_addr = 3'd0;
    tick();
    check("u0.res0_const", 32'(res_data[0]), 32'd14);
    cfg_write(1'b0, 7, 9);
    cfg_write(1'b1, 5, 9);
    cfg_write(1'b1, 3, 9);
    run(1'b0);
    im = '{15, 15, 15, 15, 15, 15, 15};
    fl = '{15, 15, 15};
    load(im, fl);
    run(1'b0);
    res_addr = 3'd4;
    tick();
    check("u0.res4_const", 32'(res_data[0]), 32'd675);
    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < 7; a++) im[a] = $urandom_range(15);
      for (int a = 0; a < 3; a++) fl[a] = $urandom_range(15);
      load(im, fl);
      run(1'b1);
    end
    arm();
    while (cyc < go_cyc + 10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check("midrst.u0.start", 32'(start[0]), 32'd0);
    check("midrst.u0.busy", 32'(busy[0]), 32'd0);
    ndone[0] = 0;
    repeat (30) tick();
    check("midrst.u0.no_done", 32'(ndone[0]), 32'd0);
    check_idle_outputs("midrst");
    check_res(1'b1);
    for (int a = 0; a < 7; a++) im[a] = $urandom_range(15);
    for (int a = 0; a < 3; a++) fl[a] = $urandom_range(15);
    load(im, fl);
    run(1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cnn_stream_driver.md
CNN_STREAM_DRIVER -- requirements
Module: cnn_stream_driver

Interface
REQ-001 Parameters, one per line:
- NUM_WIN, 5, number of convolution windows streamed per run (1..5).
- RD_LAT, 1, cycles from ReadEn high to the matching ConvResult being valid (1..3).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports, one per line:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- cfg_we  in  1  config write strobe.
- cfg_sel  in  1  write target: 0 = image row, 1 = filter.
- cfg_addr  in  3  element index: image 0..6, filter 0..2.
- cfg_data  in  4  unsigned element value.
- go  in  1  single-cycle run request.
- busy  out  1  run in progress.
- done  out  1  one-cycle run-complete pulse.
- Image  out  4  streamed image nibble to the conv layer.
- Filter  out  4  streamed filter nibble to the conv layer.
- Start  out  1  high while a valid Image/Filter pair is driven.
- ReadEn  out  1  result read request to the conv layer.
- ConvResult  in  10  result word returned by the conv layer.
- res_addr  in  3  captured-result index 0..NUM_WIN-1.
- res_data  out  10  captured result at res_addr (combinational read).

Function
REQ-004 Storage SHALL be img[0..6] (4 bits each), flt[0..2] (4 bits each) and res[0..4] (10 bits each).
REQ-005 cfg_we SHALL write img[cfg_addr] or flt[cfg_addr] only in IDLE; out-of-range addresses (image >6, filter >2) are ignored.
REQ-006 The FSM SHALL have states IDLE, STREAM, GAP, READ, DRAIN, DONE.
REQ-007 IDLE -> STREAM SHALL occur when go=1; go is ignored in every other state.
REQ-008 STREAM SHALL last NUM_WIN*3 cycles, with window w = 0..NUM_WIN-1 in the outer loop and tap t = 0..2 in the inner loop, driving Image=img[w+t], Filter=flt[t], Start=1.
REQ-009 GAP SHALL last 1 cycle with Start=0, Image=0, Filter=0.
REQ-010 READ SHALL last NUM_WIN cycles with ReadEn=1; DRAIN SHALL last RD_LAT cycles with ReadEn=0.
REQ-011 The ConvResult value present RD_LAT cycles after the k-th ReadEn-high cycle SHALL be stored into res[k], for k = 0..NUM_WIN-1.
REQ-012 DONE SHALL last 1 cycle with done=1, then the FSM returns to IDLE.
REQ-013 Image, Filter, Start, ReadEn, busy and done SHALL all be registered outputs.
REQ-014 busy SHALL be 1 in every state except IDLE.
REQ-015 Timing, with go sampled high in cycle 0 and NUM_WIN=5, RD_LAT=1:
- Start=1 in cycles 1..15.
- GAP in cycle 16.
- ReadEn=1 in cycles 17..21.
- captures in cycles 18..22.
- done=1 in cycle 23; busy=0 from cycle 24.
REQ-016 Outside STREAM, Image, Filter and Start SHALL be 0; outside READ, ReadEn SHALL be 0.
REQ-017 res contents SHALL persist until overwritten by the next run or cleared by reset; res_data for res_addr ≥ NUM_WIN SHALL be 0.
REQ-018 go asserted in the same cycle as done SHALL be ignored; a new run requires go while in IDLE.

Reset
REQ-019 rst=1 SHALL, at the next rising edge, force the FSM to IDLE and set busy, done, Start, ReadEn, Image and Filter to 0.
REQ-020 rst=1 SHALL also clear img, flt and res to 0.
REQ-021 Reset SHALL take priority over go and cfg_we in the same cycle.
REQ-022 Reset asserted mid-run SHALL abort the run with no done pulse, and outputs SHALL be 0 from the following cycle.

Verification
REQ-023 Load img = 1..7, flt = 1,2,3, pulse go, and model the conv layer returning window sums with RD_LAT=1 -> Image/Filter sequence 1/1, 2/2, 3/3, 2/1, ... 7/3 over 15 Start cycles; res = 14, 20, 26, 32, 38; done in cycle 23.
REQ-024 Load all img = 15 and all flt = 15 -> model returns 675 for every window; res[0..4] = 675 with no truncation.
REQ-025 Pulse go while busy, and write cfg during a run -> the run is unaffected and img/flt are unchanged after it.
REQ-026 Assert rst in cycle 10 of a run -> Start=0 and busy=0 from cycle 11; no done pulse; res = 0.
REQ-027 Run with NUM_WIN=1, RD_LAT=3 -> 3 Start cycles, 1 ReadEn cycle, res[0] captured 3 cycles after ReadEn, done follows.
REQ-028 Write cfg_addr=7 (image) and cfg_addr=5 (filter) -> no storage changes; the next run streams the prior values.
